// File: rtl/bus_select_decoder.sv
// Bus select decoder: turns a request (driver index + window length) into a registered
// one-hot select on DecoderOut. Each window is followed by GAP_CYCLES all-zero dead cycles,
// so two drivers are never selected in the same cycle.
//
// Ports:
//   clk         rising-edge clock
//   clr         asynchronous active-low reset
//   dec_valid   request strobe
//   dec_ready   high in IDLE only; a request is taken when valid & ready & !abort
//   dec_code    driver index 0..31
//   dec_hold    drive-window length in cycles (0 behaves as 1)
//   dec_abort   end the current window early (no done pulse); blocks acceptance in IDLE
//   DecoderOut  registered one-hot driver select, zero outside DRIVE
//   dec_busy    high whenever the state is not IDLE
//   dec_done    one-cycle pulse in the first GAP cycle after a normally completed window
module bus_select_decoder #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_code,
  input  logic [3:0]  dec_hold,
  input  logic        dec_abort,
  output logic [31:0] DecoderOut,
  output logic        dec_busy,
  output logic        dec_done
);

  localparam logic [2:0] GapInit = 3'(GAP_CYCLES);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StDrive = 2'b01,
    StGap   = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [3:0]  hold_q, hold_d;
  logic [2:0]  gap_q, gap_d;
  logic [31:0] out_q, out_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    out_d   = out_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        out_d = 32'h0;
        if (dec_valid && !dec_abort) begin
          state_d = StDrive;
          code_d  = dec_code;
          hold_d  = (dec_hold == 4'd0) ? 4'd1 : dec_hold;
          out_d   = 32'd1 << dec_code;
        end
      end
      StDrive: begin
        // hold_q counts DRIVE cycles still to run, including the current one.
        if (dec_abort || hold_q <= 4'd1) begin
          state_d = StGap;
          hold_d  = 4'd0;
          gap_d   = GapInit;
          out_d   = 32'h0;
          done_d  = !dec_abort;
        end else begin
          hold_d = hold_q - 4'd1;
          out_d  = 32'd1 << code_q;
        end
      end
      StGap: begin
        out_d = 32'h0;
        if (gap_q <= 3'd1) begin
          state_d = StIdle;
          gap_d   = 3'd0;
        end else begin
          gap_d = gap_q - 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        out_d   = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      code_q  <= 5'd0;
      hold_q  <= 4'd0;
      gap_q   <= 3'd0;
      out_q   <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign dec_ready  = (state_q == StIdle);
  assign dec_busy   = (state_q != StIdle);
  assign DecoderOut = out_q;
  assign dec_done   = done_q;

endmodule

// File: tb/tb_bus_select_decoder.sv
module tb_bus_select_decoder;

  logic        clk;
  logic        clr;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_code;
  logic [3:0]  dec_hold;
  logic        dec_abort;
  logic [31:0] DecoderOut;
  logic        dec_busy;
  logic        dec_done;

  int n_checks;
  int n_fail;

  bus_select_decoder #(
    .GAP_CYCLES(1)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_code  (dec_code),
    .dec_hold  (dec_hold),
    .dec_abort (dec_abort),
    .DecoderOut(DecoderOut),
    .dec_busy  (dec_busy),
    .dec_done  (dec_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 40 && !dec_ready; i++) tick();
    n_checks++;
    if (!dec_ready) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: dec_ready=%b after %0d cycles, required 1", name, dec_ready, i);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; dec_valid = 1'b0; dec_code = 5'd0; dec_hold = 4'd0; dec_abort = 1'b0;
    #12;
    n_checks++;
    if (DecoderOut !== 32'h0) begin
      n_fail++; $display("FAIL reset_out: got %h required 00000000", DecoderOut);
    end
    n_checks++;
    if ({dec_ready, dec_busy, dec_done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags: ready/busy/done got %b required 100",
                         {dec_ready, dec_busy, dec_done});
    end
    clr = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    dec_valid = 1'b1; dec_code = 5'd5; dec_hold = 4'd3;
    n_checks++;
    if (dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready: got %b required 1", dec_ready);
    end
    tick();
    dec_valid = 1'b0; dec_code = 5'd9; dec_hold = 4'd15;  // must be ignored mid-window
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (DecoderOut !== 32'h0000_0020 || dec_busy !== 1'b1 || dec_done !== 1'b0) begin
        n_fail++; $display("FAIL basic_drive%0d: out=%h busy=%b done=%b required 00000020 1 0",
                           i, DecoderOut, dec_busy, dec_done);
      end
      tick();
    end
    n_checks++;
    if (DecoderOut !== 32'h0 || dec_done !== 1'b1 || dec_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_gap: out=%h done=%b ready=%b required 00000000 1 0",
                         DecoderOut, dec_done, dec_ready);
    end
    tick();
    n_checks++;
    if (DecoderOut !== 32'h0 || dec_done !== 1'b0 || dec_ready !== 1'b1 || dec_busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: out=%h done=%b ready=%b busy=%b required 0 0 1 0",
                         DecoderOut, dec_done, dec_ready, dec_busy);
    end
  endtask

  task automatic test_hold_zero();
    dec_valid = 1'b1; dec_code = 5'd31; dec_hold = 4'd0;
    tick();
    dec_valid = 1'b0;
    n_checks++;
    if (DecoderOut !== 32'h8000_0000) begin
      n_fail++; $display("FAIL hold0_drive: got %h required 80000000", DecoderOut);
    end
    tick();
    n_checks++;
    if (DecoderOut !== 32'h0 || dec_done !== 1'b1) begin
      n_fail++; $display("FAIL hold0_gap: out=%h done=%b required 00000000 1", DecoderOut, dec_done);
    end
    wait_idle("hold0");
  endtask

  task automatic test_back_to_back();
    // N=2, GAP=1: second acceptance 4 edges after the first, one all-zero gap and one idle cycle.
    logic [31:0] exp_seq [6];
    exp_seq[0] = 32'h1; exp_seq[1] = 32'h1; exp_seq[2] = 32'h0;
    exp_seq[3] = 32'h0; exp_seq[4] = 32'h2; exp_seq[5] = 32'h2;
    dec_valid = 1'b1; dec_code = 5'd0; dec_hold = 4'd2;
    tick();
    dec_code = 5'd1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (DecoderOut !== exp_seq[i]) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got %h required %h", i, DecoderOut, exp_seq[i]);
      end
      tick();
    end
    dec_valid = 1'b0;
    wait_idle("b2b");
  endtask

  task automatic test_abort();
    dec_valid = 1'b1; dec_code = 5'd12; dec_hold = 4'd8;
    tick();
    dec_valid = 1'b0;
    n_checks++;
    if (DecoderOut !== 32'h0000_1000) begin
      n_fail++; $display("FAIL abort_drive1: got %h required 00001000", DecoderOut);
    end
    tick();
    dec_abort = 1'b1;
    tick();
    dec_abort = 1'b0;
    n_checks++;
    if (DecoderOut !== 32'h0 || dec_done !== 1'b0 || dec_busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_gap: out=%h done=%b busy=%b required 00000000 0 1",
                         DecoderOut, dec_done, dec_busy);
    end
    tick();
    n_checks++;
    if (dec_ready !== 1'b1 || dec_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: ready=%b done=%b required 1 0", dec_ready, dec_done);
    end
  endtask

  task automatic test_idle_abort();
    dec_valid = 1'b1; dec_abort = 1'b1; dec_code = 5'd3; dec_hold = 4'd2;
    tick();
    n_checks++;
    if (dec_busy !== 1'b0 || DecoderOut !== 32'h0) begin
      n_fail++; $display("FAIL idle_abort: busy=%b out=%h required 0 00000000", dec_busy, DecoderOut);
    end
    dec_valid = 1'b0; dec_abort = 1'b0;
  endtask

  task automatic test_mid_reset();
    dec_valid = 1'b1; dec_code = 5'd7; dec_hold = 4'd10;
    tick();
    dec_valid = 1'b0;
    tick();
    n_checks++;
    if (DecoderOut !== 32'h0000_0080) begin
      n_fail++; $display("FAIL midrst_drive: got %h required 00000080", DecoderOut);
    end
    #2 clr = 1'b0;
    #1;
    n_checks++;
    if (DecoderOut !== 32'h0 || dec_busy !== 1'b0 || dec_done !== 1'b0 || dec_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_async: out=%h busy=%b done=%b ready=%b required 0 0 0 1",
                         DecoderOut, dec_busy, dec_done, dec_ready);
    end
    dec_valid = 1'b1; dec_code = 5'd3; dec_hold = 4'd1;
    #2 clr = 1'b1;
    tick();
    dec_valid = 1'b0;
    n_checks++;
    if (DecoderOut !== 32'h0000_0008) begin
      n_fail++; $display("FAIL midrst_accept: got %h required 00000008", DecoderOut);
    end
    wait_idle("midrst");
  endtask

  task automatic test_sweep();
    for (int c = 0; c < 32; c++) begin
      logic [3:0]  h;
      logic [31:0] sel;
      int          n_drive;
      int          exp_drive;
      h = 4'($urandom_range(0, 15));
      sel = 32'd1 << c;
      exp_drive = (h == 4'd0) ? 1 : int'(h);
      n_drive = 0;
      dec_valid = 1'b1; dec_code = 5'(c); dec_hold = h;
      tick();
      dec_valid = 1'b0; dec_code = 5'(31 - c);
      for (int t = 0; t < 40 && !dec_ready; t++) begin
        n_checks++;
        if (DecoderOut !== 32'h0 && DecoderOut !== sel) begin
          n_fail++; $display("FAIL sweep_onehot: code %0d got %h required %h or 0", c, DecoderOut, sel);
        end
        n_checks++;
        if ($countones(DecoderOut) > 1) begin
          n_fail++; $display("FAIL sweep_popcount: code %0d got %0d bits required <=1",
                             c, $countones(DecoderOut));
        end
        if (DecoderOut === sel) n_drive++;
        tick();
      end
      n_checks++;
      if (n_drive != exp_drive) begin
        n_fail++; $display("FAIL sweep_len: code %0d hold %0d got %0d cycles required %0d",
                           c, h, n_drive, exp_drive);
      end
      wait_idle("sweep");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_hold_zero();
    test_back_to_back();
    test_abort();
    test_idle_abort();
    test_mid_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
